datapath_run_ctrl: RTL and testbench
====================================

Name: datapath_run_ctrl

Overview:
Run-sequencer for the vector DataPath. It holds the datapath in reset until a start request, then releases it and counts execution cycles. It detects program halt (PC reaching a fixed halt address) or a cycle-limit timeout, then snapshots the 128-bit histogram memory word. Finally it streams that word out as 16 bytes over a valid/ready byte interface to a UART/host readout.

Parameters:
PC_W, 18, width of the datapath PC.
DATA_W, 128, width of the histogram memory word; must be a multiple of 8.
HALT_PC, 18'h000C8, PC value that marks program end.
MAX_CYCLES, 1048576, RUN cycle budget before timeout.
CNT_W, 24, cycle counter width; must satisfy 2^CNT_W > MAX_CYCLES.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  run request; sampled only in IDLE.
pc  in  PC_W  current DataPath PC.
mem  in  DATA_W  DataPath histogram memory word.
dp_reset  out  1  active-high reset driven into DataPath.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse on entering DONE.
timeout  out  1  sticky; set when the run ended on the cycle budget.
cycles  out  CNT_W  RUN cycles counted for the last or current run.
tx_data  out  8  streamed byte.
tx_valid  out  1  tx_data is valid.
tx_ready  in  1  consumer accepts the byte.

Behaviour:
- Reset (reset=0, async): state=IDLE, dp_reset=1, busy=0, done=0, timeout=0, cycles=0, tx_valid=0, tx_data=0, byte index=0, snapshot register=0.
- States: IDLE, RUN, DRAIN, DUMP, DONE.
- IDLE: dp_reset=1. When start=1: go to RUN next cycle, clear cycles and timeout. dp_reset falls in that same next cycle.
- RUN: dp_reset=0. cycles increments every RUN cycle, saturating at all-ones. The test below uses cycles after increment.
  - pc==HALT_PC -> DRAIN.
  - else if cycles==MAX_CYCLES -> set timeout=1, go to DRAIN.
  - If both conditions hold in the same cycle, halt wins and timeout stays 0.
- DRAIN: exactly one cycle, dp_reset=0, so a data-memory write issued in the halt cycle lands. At the end of DRAIN, mem is captured into the snapshot register. Next state is DUMP, where dp_reset=1.
- DUMP: dp_reset=1. Byte k (k=0..DATA_W/8-1) = snapshot[8k+7:8k], LSB byte first.
  - tx_valid=1 throughout DUMP.
  - tx_data must hold stable while tx_valid=1 and tx_ready=0.
  - A transfer occurs on a cycle with tx_valid=1 and tx_ready=1. The index advances on the next cycle.
  - The transfer of the last byte -> DONE. tx_valid is 0 in DONE.
  - tx_ready held low stalls indefinitely; there is no timeout on the stream.
- DONE: one cycle, done=1, dp_reset=1 -> IDLE.
- start outside IDLE is ignored; it is not queued.
- Latency: start to dp_reset low = 1 cycle. Halt-detect cycle to first tx_valid = 2 cycles.
- Reset mid-operation (any state): immediate return to reset values. tx_valid drops asynchronously and no partial-stream resume occurs.
- busy = (state != IDLE). Outputs cycles and timeout keep their values through IDLE until the next accepted start.

Decomposition:
- Package run_ctrl_pkg: state enum (IDLE, RUN, DRAIN, DUMP, DONE), BYTES = DATA_W/8, index width $clog2(BYTES).
- One sub-module, word_serializer: loads DATA_W bits on a load pulse, runs the valid/ready byte stream, and raises a last-transfer pulse. The FSM and counters stay in the top.

Test Plan:
- Normal run: reset released, start=1 for 1 cycle, pc model reaches 18'h000C8 after 50 RUN cycles, mem=128'h0F0E0D0C0B0A09080706050403020100, tx_ready=1 -> dp_reset low 1 cycle after start, cycles=50, bytes 00,01,...,0F in order, done pulse one cycle after byte 0F, timeout=0.
- Timeout: MAX_CYCLES=100, pc never equals HALT_PC -> DRAIN after cycles=100, timeout=1, 16 bytes still streamed, done=1.
- Backpressure: tx_ready toggles 1,0,0,1 repeatedly -> each byte is held stable while ready=0, no byte lost or duplicated, exactly 16 transfers.
- Simultaneous halt and budget: pc==HALT_PC in the cycle where cycles==MAX_CYCLES -> timeout=0.
- Reset mid-DUMP: reset=0 after byte 5 -> tx_valid=0 and dp_reset=1 immediately. A following start runs a fresh stream from byte 0.
- start while busy: pulse start during RUN and DUMP -> no state change, and exactly one done per accepted start.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// rtl/run_ctrl_pkg.sv - state codes and byte-sizing helpers for the run sequencer
// Contents:
//   state_t / ST_*   sequencer state encoding (IDLE, RUN, DRAIN, DUMP, DONE)
//   bytes_of(w)      number of bytes in a w-bit word (BYTES = DATA_W/8)
//   idx_width(n)     byte-index width for n bytes ($clog2(BYTES), min 1)
package run_ctrl_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_RUN   = 3'd1;
   localparam state_t ST_DRAIN = 3'd2;
   localparam state_t ST_DUMP  = 3'd3;
   localparam state_t ST_DONE  = 3'd4;

   function automatic int bytes_of(input int width);
      return width / 8;
   endfunction

   function automatic int idx_width(input int n_bytes);
      return (n_bytes > 1) ? $clog2(n_bytes) : 1;
   endfunction

endpackage

// File: rtl/word_serializer.sv
// rtl/word_serializer.sv - loads a wide word and streams it out LSB byte first
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   load       in   capture load_data and start streaming from byte 0
//   load_data  in   DATA_W-bit word to stream
//   tx_ready   in   consumer accepts the current byte
//   tx_data    out  current byte (stable while tx_valid=1 and tx_ready=0)
//   tx_valid   out  a byte is being offered
//   last_xfer  out  the final byte transfers this cycle
module word_serializer
   import run_ctrl_pkg::*;
#(
   parameter int DATA_W = 128
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [DATA_W-1:0] load_data,
   input  logic              tx_ready,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   output logic              last_xfer
);

   localparam int BYTES = bytes_of(DATA_W);
   localparam int IDX_W = idx_width(BYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

   logic [DATA_W-1:0]     snap_q, snap_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  valid_q, valid_d;
   logic                  xfer;
   logic [BYTES-1:0][7:0] snap_bytes;

   always_comb begin
      xfer      = valid_q && tx_ready;
      last_xfer = xfer && (idx_q == LAST_IDX);
      snap_d    = snap_q;
      idx_d     = idx_q;
      valid_d   = valid_q;
      if (load) begin
         snap_d  = load_data;
         idx_d   = '0;
         valid_d = 1'b1;
      end else if (xfer) begin
         if (last_xfer) begin
            // Stream complete: index rewinds so the next load starts clean.
            idx_d   = '0;
            valid_d = 1'b0;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap_q  <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         snap_q  <= snap_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
      end
   end

   // The byte is selected straight from the held snapshot, so it cannot move
   // unless idx_q advances, which only happens on an accepted transfer.
   assign snap_bytes = snap_q;
   assign tx_data    = snap_bytes[idx_q];
   assign tx_valid   = valid_q;

endmodule

// File: rtl/datapath_run_ctrl.sv
// rtl/datapath_run_ctrl.sv - run sequencer: reset/release DataPath, detect end, dump histogram word
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   start     in   run request, sampled only in IDLE
//   pc        in   current DataPath PC
//   mem       in   DataPath histogram memory word
//   dp_reset  out  active-high reset into DataPath (low only in RUN and DRAIN)
//   busy      out  sequencer is not IDLE
//   done      out  one-cycle pulse in DONE
//   timeout   out  sticky: last run ended on the cycle budget
//   cycles    out  RUN cycles counted for the last or current run
//   tx_data   out  streamed byte
//   tx_valid  out  tx_data is valid
//   tx_ready  in   consumer accepts the byte
module datapath_run_ctrl
   import run_ctrl_pkg::*;
#(
   parameter int              PC_W       = 18,
   parameter int              DATA_W     = 128,
   parameter logic [PC_W-1:0] HALT_PC    = 18'h000C8,
   parameter int              MAX_CYCLES = 1048576,
   parameter int              CNT_W      = 24
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [PC_W-1:0]   pc,
   input  logic [DATA_W-1:0] mem,
   output logic              dp_reset,
   output logic              busy,
   output logic              done,
   output logic              timeout,
   output logic [CNT_W-1:0]  cycles,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CYCLES);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cycles_q, cycles_d;
   logic [CNT_W-1:0] cycles_inc;
   logic             timeout_q, timeout_d;
   logic             load;
   logic             last_xfer;

   always_comb begin
      state_d    = state_q;
      cycles_d   = cycles_q;
      timeout_d  = timeout_q;
      load       = 1'b0;
      cycles_inc = (&cycles_q) ? cycles_q : cycles_q + 1'b1;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_RUN;
               cycles_d  = '0;
               timeout_d = 1'b0;
            end
         end
         ST_RUN: begin
            cycles_d = cycles_inc;
            // Halt is checked first so a halt on the budget cycle is not a timeout.
            if (pc == HALT_PC) begin
               state_d = ST_DRAIN;
            end else if (cycles_inc == MAX_CNT) begin
               timeout_d = 1'b1;
               state_d   = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // DataPath still out of reset here so a store issued on the halt
            // cycle has landed by the time mem is captured at the end of DRAIN.
            load    = 1'b1;
            state_d = ST_DUMP;
         end
         ST_DUMP: begin
            if (last_xfer) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         cycles_q  <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cycles_q  <= cycles_d;
         timeout_q <= timeout_d;
      end
   end

   word_serializer #(
      .DATA_W (DATA_W)
   ) u_ser (
      .clk       (clk),
      .rst_n     (reset),
      .load      (load),
      .load_data (mem),
      .tx_ready  (tx_ready),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .last_xfer (last_xfer)
   );

   assign dp_reset = !((state_q == ST_RUN) || (state_q == ST_DRAIN));
   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_DONE);
   assign timeout  = timeout_q;
   assign cycles   = cycles_q;

endmodule

// File: tb/tb_datapath_run_ctrl.sv
// tb/tb_datapath_run_ctrl.sv - self-checking bench for datapath_run_ctrl
module tb_datapath_run_ctrl;

   localparam int          MAXC = 100;
   localparam logic [17:0] HALT = 18'h000C8;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_DRAIN = 2;
   localparam int M_DUMP  = 3;
   localparam int M_DONE  = 4;

   localparam logic [127:0] W0 = 128'h0F0E0D0C0B0A09080706050403020100;
   localparam logic [127:0] W1 = 128'hA5C3_1122_3344_5566_7788_99AA_BBCC_DDEE;
   localparam logic [127:0] W2 = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
   localparam logic [127:0] W3 = 128'hFF00FF00_80402010_08040201_7E5A3C18;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic [17:0]  pc = '0;
   logic [127:0] mem = '0;
   logic         tx_ready = 1'b1;
   logic         dp_reset, busy, done, timeout, tx_valid;
   logic [23:0]  cycles;
   logic [7:0]   tx_data;

   int n_vec = 0;
   int n_err = 0;
   int done_cnt = 0;
   int halt_at = 1000;
   int rdy_i = 0;
   bit bp_mode = 1'b0;
   logic [7:0] xfer_q[$];

   int           m_ph = M_IDLE;
   int           m_t = 0;
   int           m_k = 0;
   int           m_cycles = 0;
   bit           m_to = 1'b0;
   logic [127:0] m_word = '0;

   datapath_run_ctrl #(
      .PC_W       (18),
      .DATA_W     (128),
      .HALT_PC    (HALT),
      .MAX_CYCLES (MAXC),
      .CNT_W      (24)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .pc       (pc),
      .mem      (mem),
      .dp_reset (dp_reset),
      .busy     (busy),
      .done     (done),
      .timeout  (timeout),
      .cycles   (cycles),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a run is RUN cycles until halt (priority) or budget,
   // one drain cycle, a 16-byte dump paced by tx_ready, then one done cycle.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_ph     <= M_IDLE;
         m_t      <= 0;
         m_k      <= 0;
         m_cycles <= 0;
         m_to     <= 1'b0;
         m_word   <= '0;
      end else begin
         case (m_ph)
            M_IDLE: if (start) begin
               m_ph     <= M_RUN;
               m_t      <= 0;
               m_cycles <= 0;
               m_to     <= 1'b0;
            end
            M_RUN: begin
               m_t      <= m_t + 1;
               m_cycles <= m_t + 1;
               if (m_t + 1 == halt_at) begin
                  m_ph <= M_DRAIN;
               end else if (m_t + 1 == MAXC) begin
                  m_to <= 1'b1;
                  m_ph <= M_DRAIN;
               end
            end
            M_DRAIN: begin
               m_word <= mem;
               m_k    <= 0;
               m_ph   <= M_DUMP;
            end
            M_DUMP: if (tx_ready) begin
               m_k <= m_k + 1;
               if (m_k + 1 == 16) m_ph <= M_DONE;
            end
            default: m_ph <= M_IDLE;
         endcase
      end
   end

   // PC source and consumer: pc hits HALT on RUN cycle number halt_at;
   // tx_ready is constant 1 or the 1,0,0,1 backpressure pattern.
   initial forever begin
      @(negedge clk);
      rdy_i++;
      pc = (m_ph == M_RUN && m_t + 1 == halt_at) ? HALT : 18'(m_t + 1);
      if (bp_mode) tx_ready = ((rdy_i % 4) == 0) || ((rdy_i % 4) == 3);
      else         tx_ready = 1'b1;
   end

   initial begin
      logic       prev_stall;
      logic [7:0] prev_data;
      prev_stall = 1'b0;
      prev_data  = '0;
      @(posedge clk);
      forever begin
         @(negedge clk);
         #1;
         chk("busy", busy, m_ph != M_IDLE);
         chk("dp_reset", dp_reset, !(m_ph == M_RUN || m_ph == M_DRAIN));
         chk("done", done, m_ph == M_DONE);
         chk("tx_valid", tx_valid, m_ph == M_DUMP);
         chk("timeout", timeout, m_to);
         chk("cycles", cycles, m_cycles);
         if (m_ph == M_DUMP) chk("tx_data", tx_data, m_word[8*m_k +: 8]);
         if (prev_stall && reset) chk("hold_data", tx_data, prev_data);
         if (done) done_cnt++;
         if (tx_valid && tx_ready) xfer_q.push_back(tx_data);
         prev_stall = reset && tx_valid && !tx_ready;
         prev_data  = tx_data;
      end
   end

   task automatic do_run(input int h, input logic [127:0] w, input bit bp, input bit poke,
                         input int exp_cyc, input bit exp_to);
      int base;
      int k;
      @(negedge clk);
      halt_at = h;
      mem     = w;
      bp_mode = bp;
      xfer_q.delete();
      base  = done_cnt;
      start = 1'b1;
      k = 1;
      while (k < 3000 && done_cnt == base) begin
         @(negedge clk);
         k++;
         // Offsets 10 and 55 land in RUN and in DUMP of a halt-at-50 run.
         start = poke && (k == 10 || k == 55);
         #2;
      end
      start = 1'b0;
      repeat (4) @(negedge clk);
      #2;
      chk("done_pulses", done_cnt - base, 1);
      chk("xfer_count", xfer_q.size(), 16);
      for (int i = 0; i < 16 && i < xfer_q.size(); i++) chk("xfer_byte", xfer_q[i], w[8*i +: 8]);
      chk("final_cycles", cycles, exp_cyc);
      chk("final_timeout", timeout, exp_to);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      #1;
      chk("rst_dp_reset", dp_reset, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_tx_valid", tx_valid, 1'b0);
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_cycles", cycles, 24'd0);
      chk("rst_timeout", timeout, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      do_run(50, W0, 1'b0, 1'b0, 50, 1'b0);
      for (int i = 0; i < 16 && i < xfer_q.size(); i++) chk("normal_byte_literal", xfer_q[i], 8'(i));
      chk("normal_cycles_literal", cycles, 24'd50);

      do_run(1000, W1, 1'b0, 1'b0, 100, 1'b1);
      chk("timeout_literal", timeout, 1'b1);

      do_run(20, W2, 1'b1, 1'b0, 20, 1'b0);

      do_run(100, W3, 1'b0, 1'b0, 100, 1'b0);
      chk("simul_timeout_literal", timeout, 1'b0);

      do_run(50, W1, 1'b0, 1'b1, 50, 1'b0);

      @(negedge clk);
      halt_at = 30;
      mem     = W2;
      bp_mode = 1'b0;
      xfer_q.delete();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 300 && xfer_q.size() < 6; k++) begin
         @(negedge clk);
         #2;
      end
      chk("bytes_before_reset", xfer_q.size(), 6);
      for (int i = 0; i < 6 && i < xfer_q.size(); i++) chk("pre_reset_byte", xfer_q[i], W2[8*i +: 8]);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("midreset_tx_valid", tx_valid, 1'b0);
      chk("midreset_dp_reset", dp_reset, 1'b1);
      chk("midreset_busy", busy, 1'b0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      do_run(30, W0, 1'b0, 1'b0, 30, 1'b0);
      chk("fresh_first_byte", (xfer_q.size() > 0) ? xfer_q[0] : 8'hXX, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
